clock_core: RTL and testbench
=============================

# clock_core

Timekeeping and display datapath that responds to the mode FSM's command interface. It holds the running time (HH:MM:SS) and the alarm setting (HH:MM), applies single-step adjust commands, and counts on a 1 Hz enable. It drives the 4-digit seven-segment display and raises `alarm_match` when running time enters the alarm minute. It sits between the mode FSM, which issues the commands, and the board display pins.

## Interface
Parameters:
- `HOUR_MAX`, 23: last hour value before wrap.
- `MIN_MAX`, 59: last minute/second value before wrap.

Ports:
- `clk`  in  1  single system clock; all state on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `tick_1hz`  in  1  one-cycle strobe, once per second.
- `tick_scan`  in  1  one-cycle strobe, ~200 Hz, advances the display digit.
- `en`  in  1  1 = time counts on `tick_1hz`.
- `updown`  in  1  adjust direction: 1 = +1, 0 = −1.
- `adjust_hour`, `adjust_min`  in  1 each  one-cycle pulse: step time hours / minutes.
- `adjust_alarm_hour`, `adjust_alarm_min`  in  1 each  one-cycle pulse: step alarm hours / minutes.
- `show_alarm`  in  1  1 = display the alarm setting, 0 = display the time.
- `alarm_match`  out  1  one-cycle pulse when time reaches alarm HH:MM:00.
- `segments`  out  7  active-low; bit0 = a … bit6 = g.
- `anode_active`  out  4  active-low digit select.
- `dp`  out  1  active-low decimal point.

## Operation
- Registers:
  - `sec`, `min`: 6 bits each, range 0..MIN_MAX.
  - `hour`: 5 bits, range 0..HOUR_MAX.
  - `a_min`: 6 bits; `a_hour`: 5 bits.
  - `digit_idx`: 2 bits.
- Counting, on `tick_1hz` when `en`=1:
  - sec+1. At 59, sec wraps to 0 and carries to min.
  - min at 59 wraps to 0 and carries to hour.
  - hour at 23 wraps to 0. 23:59:59 → 00:00:00.
- Adjust (accepted regardless of `en`):
  - A pulse steps only its field by ±1 with wrap. Up: 59→0, 23→0. Down: 0→59, 0→23.
  - No carry into or out of the adjusted field. Adjusting min never touches hour; sec is untouched.
  - Several adjust pulses in one cycle: priority adjust_hour > adjust_min > adjust_alarm_hour > adjust_alarm_min; only the winner is applied.
  - An adjust pulse and `tick_1hz` in the same cycle: the adjust is applied and the tick is dropped.
- Alarm compare:
  - `alarm_match` = 1 for exactly one cycle, in the cycle after a tick-driven update produces hour==a_hour, min==a_min, sec==0.
  - Adjusts never generate `alarm_match`, even when they produce equality.
- Display:
  - Digit mapping: digit_idx 0 = minutes ones, 1 = minutes tens, 2 = hours ones, 3 = hours tens.
  - Source fields are (min, hour), or (a_min, a_hour) when `show_alarm`=1.
  - BCD split by divide-by-10 on the 6-bit/5-bit values; standard active-low 0–9 patterns.
  - `anode_active` = ~(4'b0001 << digit_idx).
  - `dp`:
    - driven low only on digit 2;
    - with `show_alarm`=0, low when sec[0]==0, giving a 1 Hz blinking colon;
    - with `show_alarm`=1, always low on digit 2.

## Timing
- All outputs are registered.
- Field updates become visible one `clk` after the strobe or pulse.
- `digit_idx` advances 0→1→2→3→0 on `tick_scan`. `segments`/`anode_active`/`dp` reflect the new digit one cycle after `tick_scan`.
- A field change is reflected on the currently displayed digit one cycle after the register update (2 cycles from the command).
- Reset (rst=0, asynchronous) forces:
  - time 00:00:00, alarm 00:00, digit_idx 0;
  - `anode_active`=4'b1110, `segments`=7'b1000000 ("0"), `dp`=1, `alarm_match`=0.
- Reset released mid-operation: counting resumes from 00:00:00 on the first `tick_1hz` after rst=1. No spurious `alarm_match`, even though the reset values equal alarm 00:00.
- `show_alarm` toggling takes effect on the next display register update; no scan restart.

## Test plan
- Reset, then en=1 and 3600 `tick_1hz` strobes → time 01:00:00. Digit 2 shows "1", digits 0/1/3 show "0".
- Preset 23:59:59 via adjusts plus ticks, then one tick → 00:00:00 with no extra carry.
- Time 12:00, `adjust_min` with updown=0 → 12:59, hour still 12. `adjust_hour` up from 23 → 00.
- Alarm 07:30; time reaches 07:29:59, then one tick → `alarm_match` high exactly 1 cycle. Adjusting time directly to 07:30 → no pulse.
- `adjust_hour` and `adjust_alarm_min` in the same cycle → only hour changes. `adjust_min` and `tick_1hz` coincident → min steps, sec unchanged.
- `show_alarm`=1 with alarm 09:45 → four `tick_scan` strobes show 5,4,9,0 on anodes 1110,1101,1011,0111, with dp low only on 1011. Assert rst mid-scan → outputs return to their reset values immediately.

Source files
------------

// File: rtl/clock_core_if.sv
// Command and display bundle between the mode FSM (master) and clock_core (slave).
interface clock_core_if;
  logic       tick_1hz;
  logic       tick_scan;
  logic       en;
  logic       updown;
  logic       adjust_hour;
  logic       adjust_min;
  logic       adjust_alarm_hour;
  logic       adjust_alarm_min;
  logic       show_alarm;
  logic       alarm_match;
  logic [6:0] segments;
  logic [3:0] anode_active;
  logic       dp;

  modport master (
    output tick_1hz, tick_scan, en, updown,
    output adjust_hour, adjust_min, adjust_alarm_hour, adjust_alarm_min, show_alarm,
    input  alarm_match, segments, anode_active, dp
  );

  modport slave (
    input  tick_1hz, tick_scan, en, updown,
    input  adjust_hour, adjust_min, adjust_alarm_hour, adjust_alarm_min, show_alarm,
    output alarm_match, segments, anode_active, dp
  );
endinterface

// File: rtl/clock_core.sv
// Time/alarm registers with single-step adjust, 1 Hz counting, alarm-minute
// detection and a registered, multiplexed 4-digit seven-segment driver.
module clock_core #(
  parameter int unsigned HOUR_MAX = 23,
  parameter int unsigned MIN_MAX  = 59
) (
  input  logic         clk,
  input  logic         rst,
  clock_core_if.slave  bus
);

  typedef enum logic [2:0] {
    CMD_NONE,
    CMD_HOUR,
    CMD_MIN,
    CMD_A_HOUR,
    CMD_A_MIN,
    CMD_TICK
  } cmd_e;

  localparam logic [5:0] MIN_LAST  = 6'(MIN_MAX);
  localparam logic [5:0] HOUR_LAST = 6'(HOUR_MAX);

  logic [5:0] sec_q, sec_d;
  logic [5:0] min_q, min_d;
  logic [4:0] hour_q, hour_d;
  logic [5:0] a_min_q, a_min_d;
  logic [4:0] a_hour_q, a_hour_d;
  logic [1:0] digit_idx_q, digit_idx_d;
  logic       alarm_match_q, alarm_match_d;
  logic [6:0] segments_q, segments_d;
  logic [3:0] anode_q, anode_d;
  logic       dp_q, dp_d;

  cmd_e       cmd;
  logic [5:0] disp_min;
  logic [5:0] disp_hour;
  logic [3:0] digit;

  function automatic logic [5:0] step_wrap(input logic [5:0] v, input logic [5:0] last,
                                           input logic up);
    if (up) return (v == last) ? 6'd0 : v + 6'd1;
    return (v == 6'd0) ? last : v - 6'd1;
  endfunction

  function automatic logic [3:0] tens_of(input logic [5:0] v);
    logic [3:0] t;
    t = 4'd0;
    for (int k = 1; k <= 6; k++) begin
      if (v >= 6'(10 * k)) t = 4'(k);
    end
    return t;
  endfunction

  function automatic logic [3:0] ones_of(input logic [5:0] v);
    return 4'(v - 6'(10 * tens_of(v)));
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  // One winner per cycle; any adjust pulse swallows a coincident tick.
  always_comb begin
    cmd = CMD_NONE;
    if (bus.adjust_hour)                cmd = CMD_HOUR;
    else if (bus.adjust_min)            cmd = CMD_MIN;
    else if (bus.adjust_alarm_hour)     cmd = CMD_A_HOUR;
    else if (bus.adjust_alarm_min)      cmd = CMD_A_MIN;
    else if (bus.tick_1hz && bus.en)    cmd = CMD_TICK;
  end

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    sec_d         = sec_q;
    min_d         = min_q;
    hour_d        = hour_q;
    a_min_d       = a_min_q;
    a_hour_d      = a_hour_q;
    alarm_match_d = 1'b0;
    case (cmd)
      CMD_HOUR:   hour_d   = 5'(step_wrap({1'b0, hour_q}, HOUR_LAST, bus.updown));
      CMD_MIN:    min_d    = step_wrap(min_q, MIN_LAST, bus.updown);
      CMD_A_HOUR: a_hour_d = 5'(step_wrap({1'b0, a_hour_q}, HOUR_LAST, bus.updown));
      CMD_A_MIN:  a_min_d  = step_wrap(a_min_q, MIN_LAST, bus.updown);
      CMD_TICK: begin
        sec_d = step_wrap(sec_q, MIN_LAST, 1'b1);
        if (sec_q == MIN_LAST) begin
          min_d = step_wrap(min_q, MIN_LAST, 1'b1);
          if (min_q == MIN_LAST) hour_d = 5'(step_wrap({1'b0, hour_q}, HOUR_LAST, 1'b1));
        end
        // Only a counted second can raise the alarm; adjusts landing on it stay silent.
        alarm_match_d = (sec_d == 6'd0) && (min_d == a_min_q) && (hour_d == a_hour_q);
      end
      default: ;
    endcase
  end

  // Display registers look at the digit being selected this edge and the settled fields.
  always_comb begin
    digit_idx_d = bus.tick_scan ? digit_idx_q + 2'd1 : digit_idx_q;
    disp_min    = bus.show_alarm ? a_min_q : min_q;
    disp_hour   = bus.show_alarm ? {1'b0, a_hour_q} : {1'b0, hour_q};
    case (digit_idx_d)
      2'd0:    digit = ones_of(disp_min);
      2'd1:    digit = tens_of(disp_min);
      2'd2:    digit = ones_of(disp_hour);
      default: digit = tens_of(disp_hour);
    endcase
    segments_d = seg7(digit);
    anode_d    = ~(4'b0001 << digit_idx_d);
    dp_d       = !((digit_idx_d == 2'd2) && (bus.show_alarm || !sec_q[0]));
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sec_q         <= '0;
      min_q         <= '0;
      hour_q        <= '0;
      a_min_q       <= '0;
      a_hour_q      <= '0;
      digit_idx_q   <= '0;
      alarm_match_q <= 1'b0;
      segments_q    <= 7'b1000000;
      anode_q       <= 4'b1110;
      dp_q          <= 1'b1;
    end else begin
      sec_q         <= sec_d;
      min_q         <= min_d;
      hour_q        <= hour_d;
      a_min_q       <= a_min_d;
      a_hour_q      <= a_hour_d;
      digit_idx_q   <= digit_idx_d;
      alarm_match_q <= alarm_match_d;
      segments_q    <= segments_d;
      anode_q       <= anode_d;
      dp_q          <= dp_d;
    end
  end

  assign bus.alarm_match  = alarm_match_q;
  assign bus.segments     = segments_q;
  assign bus.anode_active = anode_q;
  assign bus.dp           = dp_q;

endmodule

// File: tb/tb_clock_core.sv
// Self-checking bench for clock_core: directed scenarios plus a random phase, all
// compared every cycle against a seconds-of-day / minutes-of-day reference model.
module tb_clock_core;

  localparam logic [5:0] P_TICK = 6'b000001;
  localparam logic [5:0] P_SCAN = 6'b000010;
  localparam logic [5:0] P_AH   = 6'b000100;
  localparam logic [5:0] P_AM   = 6'b001000;
  localparam logic [5:0] P_AAH  = 6'b010000;
  localparam logic [5:0] P_AAM  = 6'b100000;

  logic clk = 1'b0;
  logic rst = 1'b0;

  clock_core_if bus ();

  clock_core #(.HOUR_MAX(23), .MIN_MAX(59)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                               7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  // Reference state: time as seconds of day, alarm as minutes of day, scan position.
  int t   = 0;
  int am  = 0;
  int idx = 0;

  logic en_l   = 1'b0;
  logic up_l   = 1'b1;
  logic show_l = 1'b0;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_idle();
    bus.tick_1hz          = 1'b0;
    bus.tick_scan         = 1'b0;
    bus.adjust_hour       = 1'b0;
    bus.adjust_min        = 1'b0;
    bus.adjust_alarm_hour = 1'b0;
    bus.adjust_alarm_min  = 1'b0;
    bus.en                = en_l;
    bus.updown            = up_l;
    bus.show_alarm        = show_l;
  endtask

  // Drive one cycle of commands (called at a falling edge), advance the model,
  // then check every output at the next falling edge.
  task automatic cyc(input logic [5:0] p);
    int         old_t, old_am, mm, hh, d, h, m;
    int         digs [4];
    logic [6:0] e_seg;
    logic [3:0] e_an;
    logic       e_dp, e_match;

    bus.tick_1hz          = p[0];
    bus.tick_scan         = p[1];
    bus.adjust_hour       = p[2];
    bus.adjust_min        = p[3];
    bus.adjust_alarm_hour = p[4];
    bus.adjust_alarm_min  = p[5];
    bus.en                = en_l;
    bus.updown            = up_l;
    bus.show_alarm        = show_l;

    old_t  = t;
    old_am = am;
    if (p[1]) idx = (idx + 1) % 4;

    mm = show_l ? old_am % 60 : (old_t / 60) % 60;
    hh = show_l ? old_am / 60 : old_t / 3600;
    digs[0] = mm % 10;
    digs[1] = mm / 10;
    digs[2] = hh % 10;
    digs[3] = hh / 10;
    d     = digs[idx];
    e_seg = seg_tab[d];
    e_an  = 4'b1111 ^ (4'd1 << idx);
    e_dp  = (idx == 2 && (show_l || old_t % 2 == 0)) ? 1'b0 : 1'b1;

    e_match = 1'b0;
    if (p[2]) begin
      h = (t / 3600 + (up_l ? 1 : 23)) % 24;
      t = h * 3600 + t % 3600;
    end else if (p[3]) begin
      m = ((t / 60) % 60 + (up_l ? 1 : 59)) % 60;
      t = (t / 3600) * 3600 + m * 60 + t % 60;
    end else if (p[4]) begin
      am = ((am / 60 + (up_l ? 1 : 23)) % 24) * 60 + am % 60;
    end else if (p[5]) begin
      am = (am / 60) * 60 + (am % 60 + (up_l ? 1 : 59)) % 60;
    end else if (p[0] && en_l) begin
      t = (t + 1) % 86400;
      e_match = (t % 60 == 0) && (t / 60 == am);
    end

    @(negedge clk);
    check("segments", 32'(bus.segments), 32'(e_seg));
    check("anode_active", 32'(bus.anode_active), 32'(e_an));
    check("dp", 32'(bus.dp), 32'(e_dp));
    check("alarm_match", 32'(bus.alarm_match), 32'(e_match));
    drive_idle();
  endtask

  task automatic cyc_n(input logic [5:0] p, input int n);
    for (int i = 0; i < n; i++) cyc(p);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_segments"}, 32'(bus.segments), 32'h40);
    check({tag, "_anode"}, 32'(bus.anode_active), 32'he);
    check({tag, "_dp"}, 32'(bus.dp), 32'h1);
    check({tag, "_alarm_match"}, 32'(bus.alarm_match), 32'h0);
  endtask

  initial begin
    logic [5:0] p;
    drive_idle();

    // Power-on reset.
    #12;
    check_reset_outputs("rst_init");
    @(negedge clk);
    rst = 1'b1;
    cyc_n(6'b0, 2);

    // One hour of ticks, then a full scan: 01:00 on the display.
    en_l = 1'b1;
    cyc_n(P_TICK, 3600);
    cyc_n(P_SCAN, 4);

    // Preset 23:59:59 and roll over to midnight (alarm still 00:00).
    up_l = 1'b0;
    cyc_n(P_AH, 2);
    cyc(P_AM);
    cyc_n(P_TICK, 59);
    cyc(P_TICK);
    cyc(6'b0);
    cyc_n(P_SCAN, 4);

    // 12:00 then minute down without borrow, then hour wrap upward.
    up_l = 1'b1;
    cyc_n(P_AH, 12);
    up_l = 1'b0;
    cyc(P_AM);
    cyc_n(P_SCAN, 4);
    up_l = 1'b1;
    cyc_n(P_AH, 11);
    cyc_n(P_SCAN, 4);
    cyc(P_AH);
    cyc_n(P_SCAN, 4);

    // Alarm 07:30; count through it, then adjust onto it without a pulse.
    cyc_n(P_AAH, 7);
    up_l = 1'b0;
    cyc_n(P_AAM, 30);
    up_l = 1'b1;
    cyc_n(P_AH, 7);
    up_l = 1'b0;
    cyc_n(P_AM, 30);
    cyc_n(P_TICK, 59);
    cyc(P_TICK);
    cyc_n(6'b0, 2);
    cyc(P_AM);
    up_l = 1'b1;
    cyc(P_AM);
    cyc_n(6'b0, 2);

    // Coincident commands: hour beats alarm minute; minute adjust drops the tick.
    cyc(P_AH | P_AAM);
    show_l = 1'b1;
    cyc_n(P_SCAN, 4);
    show_l = 1'b0;
    cyc_n(P_SCAN, 4);
    cyc(P_AM | P_TICK);
    cyc_n(P_SCAN, 4);
    en_l = 1'b0;
    cyc_n(P_TICK, 3);
    cyc_n(P_SCAN, 4);
    en_l = 1'b1;

    // Alarm display 09:45, scanned from digit 0.
    cyc_n(P_AAH, 2);
    cyc_n(P_AAM, 15);
    show_l = 1'b1;
    while (idx != 3) cyc(P_SCAN);
    cyc_n(P_SCAN, 4);
    show_l = 1'b0;

    // Randomized command mix.
    for (int i = 0; i < 400; i++) begin
      p = '0;
      if ($urandom_range(0, 99) < 40) p = p | P_TICK;
      if ($urandom_range(0, 99) < 30) p = p | P_SCAN;
      if ($urandom_range(0, 99) < 6)  p = p | P_AH;
      if ($urandom_range(0, 99) < 8)  p = p | P_AM;
      if ($urandom_range(0, 99) < 6)  p = p | P_AAH;
      if ($urandom_range(0, 99) < 8)  p = p | P_AAM;
      en_l   = ($urandom_range(0, 99) < 80);
      up_l   = 1'($urandom_range(0, 1));
      show_l = ($urandom_range(0, 99) < 25);
      cyc(p);
    end
    en_l   = 1'b1;
    up_l   = 1'b1;
    show_l = 1'b0;

    // Asynchronous reset in the middle of a scan.
    cyc_n(P_AM, 3);
    cyc_n(P_SCAN, 2);
    #2 rst = 1'b0;
    #1 check_reset_outputs("rst_async");
    @(negedge clk);
    check_reset_outputs("rst_hold");
    t   = 0;
    am  = 0;
    idx = 0;
    rst = 1'b1;

    // Counting resumes from midnight with no spurious alarm.
    cyc_n(P_TICK, 5);
    cyc_n(P_SCAN, 4);
    cyc_n(6'b0, 2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
